// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port 68K SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_GAP    = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VID = 1'b1;

  localparam int DEF_ACCESS_CLKS = 20;
  localparam int DEF_GAP_CLKS    = 2;

endpackage

// File: rtl/sdram_arb_timer.sv
// Loadable down-counter with zero flag; times both the ACCESS and GAP phases.
module sdram_arb_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_arbiter_68k.sv
// Arbitrates the CPU bus and a video line fetcher onto one 68K-style SDRAM controller
// port, timing each access with fixed counters since the controller gives no ack.
module sdram_arbiter_68k
  import sdram_arb_pkg::*;
#(
  parameter int ACCESS_CLKS = DEF_ACCESS_CLKS,
  parameter int GAP_CLKS    = DEF_GAP_CLKS
) (
  input  logic        clk125_mhz,
  input  logic        rst,
  input  logic        cpu_asn,
  input  logic        cpu_udsn,
  input  logic        cpu_ldsn,
  input  logic        cpu_rw,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_dtackn,
  input  logic        vid_req,
  input  logic [23:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_data,
  output logic        sd_asn,
  output logic        sd_udsn,
  output logic        sd_ldsn,
  output logic        sd_rw,
  output logic [23:0] sd_addr,
  output logic [15:0] sd_din,
  input  logic [15:0] sd_dout
);

  localparam int CNT_MAX = (ACCESS_CLKS > GAP_CLKS) ? ACCESS_CLKS : GAP_CLKS;
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CLKS - 1);

  state_e state_q, state_d;

  logic        asn_r_q, udsn_r_q, ldsn_r_q, vreq_r_q;
  logic        rw_r_q;
  logic [23:0] caddr_r_q, vaddr_r_q;
  logic [15:0] cdin_r_q;

  logic        last_grant_q, owner_q, cpu_served_q, abort_q;
  logic        sd_asn_q, sd_udsn_q, sd_ldsn_q, sd_rw_q;
  logic [23:0] sd_addr_q;
  logic [15:0] sd_din_q, cpu_dout_q, vid_data_q;
  logic        cpu_dtackn_q, vid_ack_q;

  logic             cpu_pend, vid_pend, grant, grant_port, abort_now;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  // The 68K bus and the video logic are not timed to this clock; register them once.
  always_ff @(posedge clk125_mhz) begin
    if (rst) begin
      asn_r_q  <= 1'b1;
      udsn_r_q <= 1'b1;
      ldsn_r_q <= 1'b1;
      vreq_r_q <= 1'b0;
    end else begin
      asn_r_q  <= cpu_asn;
      udsn_r_q <= cpu_udsn;
      ldsn_r_q <= cpu_ldsn;
      vreq_r_q <= vid_req;
    end
  end

  always_ff @(posedge clk125_mhz) begin
    rw_r_q    <= cpu_rw;
    caddr_r_q <= cpu_addr;
    cdin_r_q  <= cpu_din;
    vaddr_r_q <= vid_addr;
  end

  assign cpu_pend  = !asn_r_q && !(udsn_r_q && ldsn_r_q) && !cpu_served_q;
  assign vid_pend  = vreq_r_q;
  assign abort_now = (owner_q == PORT_CPU) ? asn_r_q : !vreq_r_q;

  always_ff @(posedge clk125_mhz) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_port = PORT_CPU;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_q)
      S_IDLE: begin
        if (cpu_pend || vid_pend) begin
          grant = 1'b1;
          if (cpu_pend && vid_pend) grant_port = ~last_grant_q;
          else                      grant_port = vid_pend ? PORT_VID : PORT_CPU;
          tmr_load = 1'b1;
          tmr_val  = ACC_LOAD;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr_zero) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  sdram_arb_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (clk125_mhz),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk125_mhz) begin
    if (rst) begin
      last_grant_q <= PORT_CPU;
      owner_q      <= PORT_CPU;
      cpu_served_q <= 1'b0;
      abort_q      <= 1'b0;
      sd_asn_q     <= 1'b1;
      sd_udsn_q    <= 1'b1;
      sd_ldsn_q    <= 1'b1;
      sd_rw_q      <= 1'b1;
      sd_addr_q    <= '0;
      sd_din_q     <= '0;
      cpu_dout_q   <= '0;
      cpu_dtackn_q <= 1'b1;
      vid_ack_q    <= 1'b0;
      vid_data_q   <= '0;
    end else begin
      vid_ack_q <= 1'b0;
      if (asn_r_q) begin
        cpu_served_q <= 1'b0;
        cpu_dtackn_q <= 1'b1;
      end
      if (grant) begin
        owner_q      <= grant_port;
        last_grant_q <= grant_port;
        abort_q      <= 1'b0;
        sd_asn_q     <= 1'b0;
        if (grant_port == PORT_VID) begin
          sd_udsn_q <= 1'b0;
          sd_ldsn_q <= 1'b0;
          sd_rw_q   <= 1'b1;
          sd_addr_q <= vaddr_r_q;
          sd_din_q  <= '0;
        end else begin
          sd_udsn_q <= udsn_r_q;
          sd_ldsn_q <= ldsn_r_q;
          sd_rw_q   <= rw_r_q;
          sd_addr_q <= caddr_r_q;
          sd_din_q  <= rw_r_q ? 16'h0000 : cdin_r_q;
        end
      end
      // A requester that withdraws mid-access still lets the SDRAM cycle finish,
      // but gets neither data nor acknowledge.
      if (state_q == S_ACCESS) begin
        if (abort_now) abort_q <= 1'b1;
        if (tmr_zero) begin
          sd_asn_q  <= 1'b1;
          sd_udsn_q <= 1'b1;
          sd_ldsn_q <= 1'b1;
          sd_rw_q   <= 1'b1;
          sd_din_q  <= '0;
          if (!(abort_q || abort_now)) begin
            if (owner_q == PORT_CPU) begin
              cpu_dtackn_q <= 1'b0;
              cpu_served_q <= 1'b1;
              if (sd_rw_q) cpu_dout_q <= sd_dout;
            end else begin
              vid_ack_q  <= 1'b1;
              vid_data_q <= sd_dout;
            end
          end
        end
      end
    end
  end

  assign sd_asn     = sd_asn_q;
  assign sd_udsn    = sd_udsn_q;
  assign sd_ldsn    = sd_ldsn_q;
  assign sd_rw      = sd_rw_q;
  assign sd_addr    = sd_addr_q;
  assign sd_din     = sd_din_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_dtackn = cpu_dtackn_q;
  assign vid_ack    = vid_ack_q;
  assign vid_data   = vid_data_q;

endmodule

// File: tb/tb_sdram_arbiter_68k.sv
// Directed bench for sdram_arbiter_68k with a behavioural SDRAM controller model.
module tb_sdram_arbiter_68k;

  logic        clk125_mhz = 1'b0;
  logic        rst;
  logic        cpu_asn, cpu_udsn, cpu_ldsn, cpu_rw;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_dtackn;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_data;
  logic        sd_asn, sd_udsn, sd_ldsn, sd_rw;
  logic [23:0] sd_addr;
  logic [15:0] sd_din;
  logic [15:0] sd_dout;

  int checks   = 0;
  int failures = 0;

  always #4 clk125_mhz = ~clk125_mhz;

  sdram_arbiter_68k dut (
    .clk125_mhz (clk125_mhz),
    .rst        (rst),
    .cpu_asn    (cpu_asn),
    .cpu_udsn   (cpu_udsn),
    .cpu_ldsn   (cpu_ldsn),
    .cpu_rw     (cpu_rw),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_dtackn (cpu_dtackn),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_data   (vid_data),
    .sd_asn     (sd_asn),
    .sd_udsn    (sd_udsn),
    .sd_ldsn    (sd_ldsn),
    .sd_rw      (sd_rw),
    .sd_addr    (sd_addr),
    .sd_din     (sd_din),
    .sd_dout    (sd_dout)
  );

  // Controller model: latches the address when asn falls and returns its low half.
  logic [23:0] ctl_addr = 24'h0;
  bit          ctl_busy = 1'b0;
  assign sd_dout = ctl_addr[15:0];

  always @(posedge clk125_mhz) begin
    #2;
    if (sd_asn === 1'b0 && !ctl_busy) begin
      ctl_addr = sd_addr;
      ctl_busy = 1'b1;
    end else if (sd_asn !== 1'b0) begin
      ctl_busy = 1'b0;
    end
  end

  // Strobe-timing monitor; also logs the address of every access started.
  bit          rst_abort = 1'b0;
  bit          mon_act   = 1'b0;
  bit          mon_bad   = 1'b0;
  int          mon_len   = 0;
  int          mon_gap   = 5;
  logic [23:0] mon_addr;
  logic        mon_u, mon_l, mon_rw;
  logic [23:0] acc_q[$];

  always @(posedge clk125_mhz) begin
    #1;
    if (sd_asn === 1'b0) begin
      if (!mon_act) begin
        mon_act  = 1'b1;
        mon_len  = 1;
        mon_bad  = (mon_gap < 1);
        mon_addr = sd_addr;
        mon_u    = sd_udsn;
        mon_l    = sd_ldsn;
        mon_rw   = sd_rw;
        acc_q.push_back(sd_addr);
      end else begin
        mon_len++;
        if (sd_addr !== mon_addr || sd_udsn !== mon_u || sd_ldsn !== mon_l || sd_rw !== mon_rw)
          mon_bad = 1'b1;
      end
    end else begin
      if (mon_act) begin
        if (rst_abort) begin
          rst_abort = 1'b0;
        end else begin
          checks++;
          if (mon_bad || mon_len < 18) begin
            failures++;
            $display("FAIL ctrl_model addr=0x%0h len=%0d unstable_or_no_gap=%0d required len>=18 stable gap>=1",
                     mon_addr, mon_len, mon_bad);
          end
        end
        mon_act = 1'b0;
        mon_gap = 0;
      end
      mon_gap++;
    end
  end

  typedef struct {
    logic        rw;
    logic        udsn;
    logic        ldsn;
    logic [23:0] addr;
    logic [15:0] din;
    logic        exp_u;
    logic        exp_l;
    logic        exp_rw;
    logic [15:0] exp_din;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vt[5];

  task automatic step();
    @(posedge clk125_mhz);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One CPU bus cycle from an idle arbiter: latency, controller-side view, data, dtack hold.
  task automatic cpu_access(input vec_t v, input string tag);
    int          k;
    bit          seen;
    bit          reserved;
    bit          dt_dropped;
    logic        cu, cl, crw;
    logic [23:0] ca;
    logic [15:0] cd;
    k = 0; seen = 1'b0; reserved = 1'b0; dt_dropped = 1'b0;
    cu = 1'bx; cl = 1'bx; crw = 1'bx; ca = 'x; cd = 'x;
    cpu_rw = v.rw; cpu_udsn = v.udsn; cpu_ldsn = v.ldsn;
    cpu_addr = v.addr; cpu_din = v.din; cpu_asn = 1'b0;
    while (cpu_dtackn !== 1'b0 && k < 60) begin
      step();
      k++;
      if (!seen && sd_asn === 1'b0) begin
        seen = 1'b1;
        cu = sd_udsn; cl = sd_ldsn; crw = sd_rw; ca = sd_addr; cd = sd_din;
      end
    end
    chk({tag, "_latency"}, k, 22);
    chk({tag, "_sd_addr"}, ca, v.addr);
    chk({tag, "_sd_udsn"}, cu, v.exp_u);
    chk({tag, "_sd_ldsn"}, cl, v.exp_l);
    chk({tag, "_sd_rw"}, crw, v.exp_rw);
    chk({tag, "_sd_din"}, cd, v.exp_din);
    chk({tag, "_cpu_dout"}, cpu_dout, v.exp_dout);
    for (int i = 0; i < 30; i++) begin
      step();
      if (sd_asn !== 1'b1) reserved = 1'b1;
      if (cpu_dtackn !== 1'b0) dt_dropped = 1'b1;
    end
    chk({tag, "_no_reserve"}, reserved, 1'b0);
    chk({tag, "_dtack_held"}, dt_dropped, 1'b0);
    cpu_asn = 1'b1; cpu_udsn = 1'b1; cpu_ldsn = 1'b1;
    step();
    step();
    chk({tag, "_dtack_release"}, cpu_dtackn, 1'b1);
    step();
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t vr;
    int   k;
    int   low;
    bit   flag;
    bit   flag2;

    vt[0] = '{1'b1, 1'b0, 1'b0, 24'h00ABCD, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hABCD};
    vt[1] = '{1'b0, 1'b1, 1'b0, 24'h000100, 16'h5A5A, 1'b1, 1'b0, 1'b0, 16'h5A5A, 16'hABCD};
    vt[2] = '{1'b0, 1'b0, 1'b1, 24'hFF8001, 16'hA5C3, 1'b0, 1'b1, 1'b0, 16'hA5C3, 16'hABCD};
    vt[3] = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF};
    vt[4] = '{1'b1, 1'b0, 1'b1, 24'h123456, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h3456};

    rst = 1'b1;
    cpu_asn = 1'b1; cpu_udsn = 1'b1; cpu_ldsn = 1'b1; cpu_rw = 1'b1;
    cpu_addr = '0; cpu_din = '0; vid_req = 1'b0; vid_addr = '0;
    repeat (3) step();

    chk("rst_sd_asn", sd_asn, 1'b1);
    chk("rst_sd_udsn", sd_udsn, 1'b1);
    chk("rst_sd_ldsn", sd_ldsn, 1'b1);
    chk("rst_sd_rw", sd_rw, 1'b1);
    chk("rst_sd_addr", sd_addr, 24'h0);
    chk("rst_sd_din", sd_din, 16'h0);
    chk("rst_dtackn", cpu_dtackn, 1'b1);
    chk("rst_vid_ack", vid_ack, 1'b0);
    chk("rst_cpu_dout", cpu_dout, 16'h0);
    chk("rst_vid_data", vid_data, 16'h0);

    rst = 1'b0;
    step();
    step();

    for (int i = 0; i < 5; i++) cpu_access(vt[i], $sformatf("vec%0d", i));

    // Lone video request.
    acc_q.delete();
    k = 0; flag = 1'b0; low = 0;
    vid_addr = 24'h001234; vid_req = 1'b1;
    while (vid_ack !== 1'b1 && k < 60) begin
      step();
      k++;
      if (sd_asn === 1'b0 && !flag) begin
        flag = 1'b1;
        low = {29'd0, sd_udsn, sd_ldsn, sd_rw};
      end
    end
    vid_req = 1'b0;
    chk("vid_latency", k, 22);
    chk("vid_data", vid_data, 16'h1234);
    chk("vid_strobes_u_l_rw", low, 3'b001);
    step();
    chk("vid_ack_one_cycle", vid_ack, 1'b0);
    repeat (10) step();
    chk("vid_single_access", acc_q.size(), 1);
    chk("vid_cpu_dout_kept", cpu_dout, 16'h3456);

    // Simultaneous requests after reset, then both held: V,C,V,C.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    acc_q.delete();
    cpu_addr = 24'h000C00; cpu_rw = 1'b1; cpu_udsn = 1'b0; cpu_ldsn = 1'b0; cpu_asn = 1'b0;
    vid_addr = 24'h000B00; vid_req = 1'b1;
    fork
      begin
        for (int n = 0; n < 2; n++) begin
          int w;
          w = 0;
          while (cpu_dtackn !== 1'b0 && w < 200) begin
            step();
            w++;
          end
          cpu_asn = 1'b1;
          step();
          step();
          if (n == 0) cpu_asn = 1'b0;
        end
      end
      begin
        int w2;
        w2 = 0;
        while (acc_q.size() < 4 && w2 < 400) begin
          step();
          w2++;
        end
      end
    join
    vid_req = 1'b0;
    cpu_udsn = 1'b1; cpu_ldsn = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (vid_ack === 1'b1) flag = 1'b1;
    end
    chk("alt_grant0", (acc_q.size() > 0) ? acc_q[0] : 24'hxxxxxx, 24'h000B00);
    chk("alt_grant1", (acc_q.size() > 1) ? acc_q[1] : 24'hxxxxxx, 24'h000C00);
    chk("alt_grant2", (acc_q.size() > 2) ? acc_q[2] : 24'hxxxxxx, 24'h000B00);
    chk("alt_grant3", (acc_q.size() > 3) ? acc_q[3] : 24'hxxxxxx, 24'h000C00);
    chk("vid_drop_no_ack", flag, 1'b0);

    // Reset pulsed mid-ACCESS.
    cpu_addr = 24'h000777; cpu_rw = 1'b1; cpu_udsn = 1'b0; cpu_ldsn = 1'b0; cpu_asn = 1'b0;
    repeat (10) step();
    chk("pre_rst_in_access", sd_asn, 1'b0);
    rst_abort = 1'b1;
    rst = 1'b1;
    cpu_asn = 1'b1; cpu_udsn = 1'b1; cpu_ldsn = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_sd_asn", sd_asn, 1'b1);
    chk("rst_mid_sd_udsn", sd_udsn, 1'b1);
    chk("rst_mid_sd_ldsn", sd_ldsn, 1'b1);
    flag = 1'b0; flag2 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cpu_dtackn !== 1'b1) flag = 1'b1;
      if (vid_ack !== 1'b0) flag2 = 1'b1;
    end
    chk("rst_mid_no_dtack", flag, 1'b0);
    chk("rst_mid_no_vid_ack", flag2, 1'b0);
    vr = '{1'b1, 1'b0, 1'b0, 24'h000888, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0888};
    cpu_access(vr, "post_rst");

    // CPU abandons its cycle 5 cycles into ACCESS while video waits.
    acc_q.delete();
    low = 0; flag = 1'b0; k = 0;
    cpu_addr = 24'h000666; cpu_rw = 1'b1; cpu_udsn = 1'b0; cpu_ldsn = 1'b0; cpu_asn = 1'b0;
    repeat (6) begin
      step();
      if (sd_asn === 1'b0) low++;
    end
    cpu_asn = 1'b1; cpu_udsn = 1'b1; cpu_ldsn = 1'b1;
    vid_addr = 24'h000555; vid_req = 1'b1;
    while (sd_asn === 1'b0 && k < 40) begin
      step();
      k++;
      if (sd_asn === 1'b0) low++;
      if (cpu_dtackn !== 1'b1) flag = 1'b1;
    end
    chk("abort_access_len", low, 20);
    k = 0;
    while (vid_ack !== 1'b1 && k < 80) begin
      step();
      k++;
      if (cpu_dtackn !== 1'b1) flag = 1'b1;
    end
    vid_req = 1'b0;
    chk("abort_no_dtack", flag, 1'b0);
    chk("abort_vid_ack_seen", vid_ack, 1'b1);
    chk("abort_vid_data", vid_data, 16'h0555);
    chk("abort_cpu_dout_kept", cpu_dout, 16'h0888);
    chk("abort_next_grant", (acc_q.size() > 1) ? acc_q[1] : 24'hxxxxxx, 24'h000555);
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
